// File: rtl/axi2_rr_arbiter_if.sv
// rtl/axi2_rr_arbiter_if.sv - AXI3 five-channel bundle shared by both master ports and the bridge port
interface axi2_rr_arbiter_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;

   logic [ID_WIDTH-1:0]   wid;
   logic [63:0]           wdata;
   logic [7:0]            wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [3:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [63:0]           rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi2_rr_arbiter.sv
// rtl/axi2_rr_arbiter.sv - two-master round-robin AXI3 arbiter, one transaction in flight
module axi2_rr_arbiter (
   input  logic              ACLK,
   input  logic              ARESETN,
   axi2_rr_arbiter_if.slave  m0,
   axi2_rr_arbiter_if.slave  m1,
   axi2_rr_arbiter_if.master s,
   output logic              LEN_ERR,
   output logic [1:0]        GRANT,
   output logic              BUSY
);
   typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [3:0] beat_cnt;
   logic [3:0] awlen_q;

   logic [3:0] req;
   logic [1:0] sel;
   logic [1:0] idx;
   logic       found;

   assign req = {m1.arvalid, m1.awvalid, m0.arvalid, m0.awvalid};

   always_comb begin
      sel   = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   // GRANT[1] picks the master; the active channel comes from the state alone.
   logic gm;
   logic ph_aw, ph_w, ph_b, ph_ar, ph_r;
   assign gm    = GRANT[1];
   assign ph_aw = (state == WADDR);
   assign ph_w  = (state == WDATA);
   assign ph_b  = (state == WRESP);
   assign ph_ar = (state == RADDR);
   assign ph_r  = (state == RDATA);

   assign s.awvalid = ph_aw & (gm ? m1.awvalid : m0.awvalid);
   assign s.awid    = ph_aw ? (gm ? m1.awid    : m0.awid)    : '0;
   assign s.awaddr  = ph_aw ? (gm ? m1.awaddr  : m0.awaddr)  : '0;
   assign s.awlen   = ph_aw ? (gm ? m1.awlen   : m0.awlen)   : '0;
   assign s.awsize  = ph_aw ? (gm ? m1.awsize  : m0.awsize)  : '0;
   assign s.awburst = ph_aw ? (gm ? m1.awburst : m0.awburst) : '0;
   assign m0.awready = ph_aw & ~gm & s.awready;
   assign m1.awready = ph_aw &  gm & s.awready;

   assign s.wvalid = ph_w & (gm ? m1.wvalid : m0.wvalid);
   assign s.wid    = ph_w ? (gm ? m1.wid   : m0.wid)   : '0;
   assign s.wdata  = ph_w ? (gm ? m1.wdata : m0.wdata) : '0;
   assign s.wstrb  = ph_w ? (gm ? m1.wstrb : m0.wstrb) : '0;
   assign s.wlast  = ph_w & (gm ? m1.wlast : m0.wlast);
   assign m0.wready = ph_w & ~gm & s.wready;
   assign m1.wready = ph_w &  gm & s.wready;

   assign s.bready  = ph_b & (gm ? m1.bready : m0.bready);
   assign m0.bvalid = ph_b & ~gm & s.bvalid;
   assign m1.bvalid = ph_b &  gm & s.bvalid;
   assign m0.bid    = (ph_b & ~gm) ? s.bid   : '0;
   assign m1.bid    = (ph_b &  gm) ? s.bid   : '0;
   assign m0.bresp  = (ph_b & ~gm) ? s.bresp : '0;
   assign m1.bresp  = (ph_b &  gm) ? s.bresp : '0;

   assign s.arvalid = ph_ar & (gm ? m1.arvalid : m0.arvalid);
   assign s.arid    = ph_ar ? (gm ? m1.arid    : m0.arid)    : '0;
   assign s.araddr  = ph_ar ? (gm ? m1.araddr  : m0.araddr)  : '0;
   assign s.arlen   = ph_ar ? (gm ? m1.arlen   : m0.arlen)   : '0;
   assign s.arsize  = ph_ar ? (gm ? m1.arsize  : m0.arsize)  : '0;
   assign s.arburst = ph_ar ? (gm ? m1.arburst : m0.arburst) : '0;
   assign m0.arready = ph_ar & ~gm & s.arready;
   assign m1.arready = ph_ar &  gm & s.arready;

   assign s.rready  = ph_r & (gm ? m1.rready : m0.rready);
   assign m0.rvalid = ph_r & ~gm & s.rvalid;
   assign m1.rvalid = ph_r &  gm & s.rvalid;
   assign m0.rid    = (ph_r & ~gm) ? s.rid   : '0;
   assign m1.rid    = (ph_r &  gm) ? s.rid   : '0;
   assign m0.rdata  = (ph_r & ~gm) ? s.rdata : '0;
   assign m1.rdata  = (ph_r &  gm) ? s.rdata : '0;
   assign m0.rresp  = (ph_r & ~gm) ? s.rresp : '0;
   assign m1.rresp  = (ph_r &  gm) ? s.rresp : '0;
   assign m0.rlast  = ph_r & ~gm & s.rlast;
   assign m1.rlast  = ph_r &  gm & s.rlast;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = s.awvalid & s.awready;
   assign w_hs  = s.wvalid  & s.wready;
   assign b_hs  = s.bvalid  & s.bready;
   assign ar_hs = s.arvalid & s.arready;
   assign r_hs  = s.rvalid  & s.rready;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         GRANT    <= 2'd0;
         BUSY     <= 1'b0;
         LEN_ERR  <= 1'b0;
         beat_cnt <= 4'd0;
         awlen_q  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  GRANT <= sel;
                  ptr   <= sel + 2'd1;
                  BUSY  <= 1'b1;
                  state <= sel[0] ? RADDR : WADDR;
               end
            end
            WADDR: begin
               if (aw_hs) begin
                  awlen_q  <= s.awlen;
                  beat_cnt <= 4'd0;
                  state    <= WDATA;
               end
            end
            WDATA: begin
               // A missing WLAST on the AWLEN beat is flagged but the burst runs on to WLAST.
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 4'd1;
                  if (s.wlast) begin
                     if (beat_cnt != awlen_q)
                        LEN_ERR <= 1'b1;
                     state <= WRESP;
                  end else if (beat_cnt == awlen_q) begin
                     LEN_ERR <= 1'b1;
                  end
               end
            end
            WRESP: begin
               if (b_hs) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            RADDR: begin
               if (ar_hs)
                  state <= RDATA;
            end
            RDATA: begin
               if (r_hs && s.rlast) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi2_rr_arbiter.sv
// tb/tb_axi2_rr_arbiter.sv - directed self-checking bench for axi2_rr_arbiter
module tb_axi2_rr_arbiter;
   logic       ACLK;
   logic       ARESETN;
   logic       LEN_ERR;
   logic [1:0] GRANT;
   logic       BUSY;

   int n_checks = 0;
   int n_pass   = 0;

   logic       rec_busy  [0:15];
   logic [1:0] rec_grant [0:15];

   axi2_rr_arbiter_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) m0_if ();
   axi2_rr_arbiter_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) m1_if ();
   axi2_rr_arbiter_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) s_if ();

   axi2_rr_arbiter dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .m0      (m0_if),
      .m1      (m1_if),
      .s       (s_if),
      .LEN_ERR (LEN_ERR),
      .GRANT   (GRANT),
      .BUSY    (BUSY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task tick();
      @(posedge ACLK);
      #1;
   endtask

   task idle_all();
      m0_if.awid = '0; m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = '0; m0_if.awburst = '0; m0_if.awvalid = 0;
      m0_if.wid = '0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.wvalid = 0; m0_if.bready = 0;
      m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arburst = '0; m0_if.arvalid = 0;
      m0_if.rready = 0;
      m1_if.awid = '0; m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = '0; m1_if.awburst = '0; m1_if.awvalid = 0;
      m1_if.wid = '0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.wvalid = 0; m1_if.bready = 0;
      m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arburst = '0; m1_if.arvalid = 0;
      m1_if.rready = 0;
      s_if.awready = 0; s_if.wready = 0; s_if.arready = 0;
      s_if.bid = '0; s_if.bresp = '0; s_if.bvalid = 0;
      s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 0; s_if.rvalid = 0;
   endtask

   // Responsive masters: each VALID drops on the cycle after its handshake.
   task run_cycles(input int n);
      logic [5:0] hs;
      for (int c = 0; c < n; c++) begin
         hs = {m0_if.awvalid & m0_if.awready, m0_if.wvalid & m0_if.wready, m0_if.arvalid & m0_if.arready,
               m1_if.awvalid & m1_if.awready, m1_if.wvalid & m1_if.wready, m1_if.arvalid & m1_if.arready};
         tick();
         if (hs[5]) m0_if.awvalid = 0;
         if (hs[4]) m0_if.wvalid  = 0;
         if (hs[3]) m0_if.arvalid = 0;
         if (hs[2]) m1_if.awvalid = 0;
         if (hs[1]) m1_if.wvalid  = 0;
         if (hs[0]) m1_if.arvalid = 0;
         #1;
         rec_busy[c]  = BUSY;
         rec_grant[c] = GRANT;
      end
   endtask

   task test_reset();
      ARESETN = 0;
      idle_all();
      m0_if.awvalid = 1;
      m1_if.arvalid = 1;
      s_if.bvalid = 1;
      s_if.rvalid = 1;
      repeat (3) tick();
      n_checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy got=%0b want=0", BUSY); else n_pass++;
      n_checks++; if (GRANT !== 2'd0) $display("FAIL rst_grant got=%0d want=0", GRANT); else n_pass++;
      n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL rst_len_err got=%0b want=0", LEN_ERR); else n_pass++;
      n_checks++;
      if ({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready} !== 5'b0)
         $display("FAIL rst_s_side got=%b want=00000", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready});
      else n_pass++;
      n_checks++;
      if ({m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.arready, m0_if.rvalid,
           m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.arready, m1_if.rvalid} !== 10'b0)
         $display("FAIL rst_m_side got=%b want=0", {m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.arready, m0_if.rvalid,
                  m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.arready, m1_if.rvalid});
      else n_pass++;
      idle_all();
      tick();
      ARESETN = 1;
      tick();
   endtask

   task test_single_write();
      logic [7:0]  strb;
      logic [63:0] data;
      idle_all();
      s_if.awready = 1; s_if.wready = 1;
      m0_if.awid = 4'd6; m0_if.awaddr = 32'h1; m0_if.awlen = 4'd3; m0_if.awsize = 3'd3; m0_if.awburst = 2'd1;
      m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.wid = 4'd6; m0_if.wstrb = 8'hFE; m0_if.bready = 1;
      #1;
      n_checks++; if (m0_if.wready !== 1'b0) $display("FAIL early_w_idle wready got=%0b want=0", m0_if.wready); else n_pass++;
      tick();
      n_checks++; if ({BUSY, GRANT} !== 3'b100) $display("FAIL sw_grant busy/grant got=%b want=100", {BUSY, GRANT}); else n_pass++;
      n_checks++;
      if ({s_if.awvalid, s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst} !== {1'b1, 4'd6, 32'h1, 4'd3, 3'd3, 2'd1})
         $display("FAIL sw_aw_fwd got=%h want=%h", {s_if.awvalid, s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst},
                  {1'b1, 4'd6, 32'h1, 4'd3, 3'd3, 2'd1});
      else n_pass++;
      n_checks++;
      if ({m0_if.awready, m0_if.wready, s_if.wvalid, m1_if.awready} !== 4'b1000)
         $display("FAIL sw_waddr_ready got=%b want=1000", {m0_if.awready, m0_if.wready, s_if.wvalid, m1_if.awready});
      else n_pass++;
      tick();
      m0_if.awvalid = 0;
      for (int b = 0; b < 4; b++) begin
         strb = (b == 0) ? 8'hFE : ((b == 3) ? 8'h7F : 8'hFF);
         data = 64'h1111_2222_0000_0000 | 64'(b);
         m0_if.wdata = data; m0_if.wstrb = strb; m0_if.wlast = (b == 3);
         #1;
         n_checks++;
         if ({s_if.wvalid, s_if.wlast, s_if.wid, s_if.wstrb, s_if.wdata, m0_if.wready} !== {1'b1, (b == 3), 4'd6, strb, data, 1'b1})
            $display("FAIL sw_w_beat%0d got=%h want=%h", b, {s_if.wvalid, s_if.wlast, s_if.wid, s_if.wstrb, s_if.wdata, m0_if.wready},
                     {1'b1, (b == 3), 4'd6, strb, data, 1'b1});
         else n_pass++;
         tick();
      end
      m0_if.wvalid = 0; m0_if.wlast = 0;
      s_if.bvalid = 1; s_if.bid = 4'd6; s_if.bresp = 2'b01;
      #1;
      n_checks++;
      if ({m0_if.bvalid, m0_if.bid, m0_if.bresp, m1_if.bvalid, s_if.bready} !== {1'b1, 4'd6, 2'b01, 1'b0, 1'b1})
         $display("FAIL sw_b_route got=%b want=%b", {m0_if.bvalid, m0_if.bid, m0_if.bresp, m1_if.bvalid, s_if.bready},
                  {1'b1, 4'd6, 2'b01, 1'b0, 1'b1});
      else n_pass++;
      tick();
      s_if.bvalid = 0;
      n_checks++; if ({BUSY, LEN_ERR} !== 2'b00) $display("FAIL sw_done busy/len_err got=%b want=00", {BUSY, LEN_ERR}); else n_pass++;
   endtask

   task test_contention();
      logic [13:0] eb;
      logic [1:0]  eg [0:13];
      eb = 14'b11101101110110;
      eg = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
      ARESETN = 0;
      idle_all();
      tick();
      ARESETN = 1;
      s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
      s_if.bvalid = 1; s_if.rvalid = 1; s_if.rlast = 1;
      m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.wlast = 1; m0_if.bready = 1; m0_if.arvalid = 1; m0_if.rready = 1;
      m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.wlast = 1; m1_if.bready = 1; m1_if.arvalid = 1; m1_if.rready = 1;
      #1;
      run_cycles(14);
      for (int c = 0; c < 14; c++) begin
         n_checks++;
         if (rec_busy[c] !== eb[13-c]) $display("FAIL cont_busy c%0d got=%0b want=%0b", c, rec_busy[c], eb[13-c]);
         else n_pass++;
         if (eb[13-c]) begin
            n_checks++;
            if (rec_grant[c] !== eg[c]) $display("FAIL cont_grant c%0d got=%0d want=%0d", c, rec_grant[c], eg[c]);
            else n_pass++;
         end
      end
   endtask

   task test_pointer_wrap();
      logic [7:0] eb;
      logic [1:0] eg [0:7];
      eb = 8'b11101110;
      eg = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
      m0_if.awvalid = 1; m0_if.wvalid = 1;
      m1_if.awvalid = 1; m1_if.wvalid = 1;
      #1;
      run_cycles(8);
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (rec_busy[c] !== eb[7-c]) $display("FAIL wrap_busy c%0d got=%0b want=%0b", c, rec_busy[c], eb[7-c]);
         else n_pass++;
         if (eb[7-c]) begin
            n_checks++;
            if (rec_grant[c] !== eg[c]) $display("FAIL wrap_grant c%0d got=%0d want=%0d", c, rec_grant[c], eg[c]);
            else n_pass++;
         end
      end
   endtask

   task test_read();
      logic [63:0] data;
      logic        m0_seen;
      logic        bad;
      idle_all();
      s_if.arready = 1; s_if.rvalid = 1; s_if.rid = 4'h9;
      m1_if.arid = 4'h9; m1_if.araddr = 32'h8000_0040; m1_if.arlen = 4'd15; m1_if.arsize = 3'd3; m1_if.arburst = 2'd1;
      m1_if.arvalid = 1; m1_if.rready = 1; m0_if.rready = 1;
      #1;
      n_checks++; if (m1_if.rvalid !== 1'b0) $display("FAIL rd_idle_rvalid got=%0b want=0", m1_if.rvalid); else n_pass++;
      tick();
      n_checks++;
      if ({GRANT, s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen} !== {2'd3, 1'b1, 4'h9, 32'h8000_0040, 4'd15})
         $display("FAIL rd_ar_fwd got=%h want=%h", {GRANT, s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen},
                  {2'd3, 1'b1, 4'h9, 32'h8000_0040, 4'd15});
      else n_pass++;
      tick();
      m1_if.arvalid = 0;
      m0_seen = 0;
      bad = 0;
      for (int b = 0; b < 16; b++) begin
         data = 64'hA5A5_0000_0000_0000 | 64'(b);
         s_if.rdata = data; s_if.rlast = (b == 15);
         #1;
         m0_seen = m0_seen | m0_if.rvalid;
         if ({m1_if.rvalid, m1_if.rlast, m1_if.rid, m1_if.rdata, s_if.rready} !== {1'b1, (b == 15), 4'h9, data, 1'b1}) begin
            bad = 1;
            $display("FAIL rd_beat%0d got=%h want=%h", b, {m1_if.rvalid, m1_if.rlast, m1_if.rid, m1_if.rdata, s_if.rready},
                     {1'b1, (b == 15), 4'h9, data, 1'b1});
         end
         tick();
      end
      n_checks++; if (bad !== 1'b0) $display("FAIL rd_beats got=bad want=all16"); else n_pass++;
      n_checks++; if (m0_seen !== 1'b0) $display("FAIL rd_m0_rvalid got=%0b want=0", m0_seen); else n_pass++;
      n_checks++; if (BUSY !== 1'b0) $display("FAIL rd_done busy got=%0b want=0", BUSY); else n_pass++;
      s_if.rvalid = 0; s_if.rlast = 0;
   endtask

   task test_len_err();
      idle_all();
      s_if.awready = 1; s_if.wready = 1;
      m0_if.awlen = 4'd2; m0_if.awid = 4'd3; m0_if.awvalid = 1;
      m0_if.wvalid = 1; m0_if.wlast = 1; m0_if.bready = 1;
      tick();
      n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL le_pre got=%0b want=0", LEN_ERR); else n_pass++;
      tick();
      m0_if.awvalid = 0;
      tick();
      m0_if.wvalid = 0; m0_if.wlast = 0;
      n_checks++; if ({LEN_ERR, BUSY} !== 2'b11) $display("FAIL le_set len_err/busy got=%b want=11", {LEN_ERR, BUSY}); else n_pass++;
      s_if.bvalid = 1; s_if.bid = 4'd3;
      #1;
      n_checks++; if ({m0_if.bvalid, m0_if.bid} !== {1'b1, 4'd3}) $display("FAIL le_b_route got=%b want=10011", {m0_if.bvalid, m0_if.bid}); else n_pass++;
      tick();
      s_if.bvalid = 0;
      m1_if.awlen = 4'd1; m1_if.awvalid = 1; m1_if.wvalid = 1; m1_if.wlast = 0; m1_if.bready = 1;
      tick();
      n_checks++; if (GRANT !== 2'd2) $display("FAIL le_clean_grant got=%0d want=2", GRANT); else n_pass++;
      tick();
      m1_if.awvalid = 0;
      tick();
      m1_if.wlast = 1;
      tick();
      m1_if.wvalid = 0; m1_if.wlast = 0;
      s_if.bvalid = 1;
      #1;
      n_checks++; if ({m1_if.bvalid, m0_if.bvalid} !== 2'b10) $display("FAIL le_clean_b got=%b want=10", {m1_if.bvalid, m0_if.bvalid}); else n_pass++;
      tick();
      s_if.bvalid = 0;
      n_checks++; if ({LEN_ERR, BUSY} !== 2'b10) $display("FAIL le_sticky len_err/busy got=%b want=10", {LEN_ERR, BUSY}); else n_pass++;
   endtask

   task test_reset_mid_burst();
      idle_all();
      s_if.awready = 1; s_if.wready = 1;
      m0_if.awlen = 4'd7; m0_if.awvalid = 1; m0_if.bready = 1;
      tick();
      tick();
      m0_if.awvalid = 0;
      m0_if.wvalid = 1;
      tick();
      tick();
      s_if.bvalid = 1; s_if.rvalid = 1;
      #1;
      n_checks++; if ({BUSY, s_if.wvalid} !== 2'b11) $display("FAIL mid_pre busy/wvalid got=%b want=11", {BUSY, s_if.wvalid}); else n_pass++;
      ARESETN = 0;
      #1;
      n_checks++; if ({BUSY, GRANT, LEN_ERR} !== 4'b0000) $display("FAIL mid_rst busy/grant/len_err got=%b want=0000", {BUSY, GRANT, LEN_ERR}); else n_pass++;
      n_checks++;
      if ({s_if.wvalid, s_if.awvalid, s_if.bready, m0_if.wready, m0_if.bvalid, m0_if.rvalid} !== 6'b0)
         $display("FAIL mid_rst_outputs got=%b want=000000", {s_if.wvalid, s_if.awvalid, s_if.bready, m0_if.wready, m0_if.bvalid, m0_if.rvalid});
      else n_pass++;
      idle_all();
      tick();
      ARESETN = 1;
      s_if.awready = 1; s_if.wready = 1; s_if.arready = 1; s_if.rvalid = 1; s_if.rlast = 1;
      m0_if.awlen = 4'd0; m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.wlast = 0; m0_if.bready = 1;
      m1_if.arvalid = 1; m1_if.rready = 1;
      tick();
      n_checks++; if ({BUSY, GRANT} !== 3'b100) $display("FAIL post_rst_grant busy/grant got=%b want=100", {BUSY, GRANT}); else n_pass++;
      tick();
      m0_if.awvalid = 0;
      tick();
      n_checks++;
      if ({LEN_ERR, BUSY, s_if.wvalid} !== 3'b111) $display("FAIL overrun len_err/busy/wvalid got=%b want=111", {LEN_ERR, BUSY, s_if.wvalid});
      else n_pass++;
      m0_if.wlast = 1;
      tick();
      m0_if.wvalid = 0; m0_if.wlast = 0;
      s_if.bvalid = 1;
      tick();
      s_if.bvalid = 0;
      n_checks++; if (BUSY !== 1'b0) $display("FAIL overrun_done busy got=%0b want=0", BUSY); else n_pass++;
      tick();
      n_checks++; if ({BUSY, GRANT} !== 3'b111) $display("FAIL post_rst_read busy/grant got=%b want=111", {BUSY, GRANT}); else n_pass++;
      tick();
      m1_if.arvalid = 0;
      tick();
      n_checks++; if (BUSY !== 1'b0) $display("FAIL post_rst_read_done busy got=%0b want=0", BUSY); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_pointer_wrap();
      test_read();
      test_len_err();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
